key_debounce_multi: RTL

- Parametrised N-channel key debouncer. Successor to the single-key, press-only debouncer.
- Debounces both press and release per channel, with selectable input polarity.
- Emits one-cycle press, release, long-press and optional auto-repeat pulses.
- Sits between raw board push-buttons and the control FSMs that consume key events.

---
 rtl/key_debounce_multi_if.sv | 23 ++
 rtl/key_debounce_multi.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/key_debounce_multi_if.sv
// Key event bus: raw pins in, debounced level and one-cycle event pulses out.
interface key_debounce_multi_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] key;
    logic [N_CH-1:0] lo_key;
    logic [N_CH-1:0] press_p;
    logic [N_CH-1:0] release_p;
    logic [N_CH-1:0] long_p;
    logic [N_CH-1:0] rep_p;

    // Driven by the board / testbench side
    modport master (
        output key,
        input  lo_key, press_p, release_p, long_p, rep_p
    );

    // Debouncer side
    modport slave (
        input  key,
        output lo_key, press_p, release_p, long_p, rep_p
    );
endinterface

// File: rtl/key_debounce_multi.sv
// N-channel key debouncer: two-flop synchroniser, press/release debounce,
// long-press detection and optional auto-repeat. Channels are independent.
module key_debounce_multi #(
    parameter int N_CH       = 4,
    parameter int DEB_CNT    = 1000000,
    parameter int ACTIVE_LOW = 1,
    parameter int LONG_CNT   = 50000000,
    parameter int REPEAT_EN  = 0,
    parameter int REPEAT_CNT = 10000000
) (
    input  logic              clk,
    input  logic              rst,
    key_debounce_multi_if.slave bus
);

    localparam int DW = $clog2(DEB_CNT);
    localparam int HW = $clog2(LONG_CNT + 1);
    localparam int RW = (REPEAT_CNT > 1) ? $clog2(REPEAT_CNT) : 1;

    localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CNT - 1);
    localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_CNT - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CNT);
    localparam logic [RW-1:0] REP_MAX  = RW'(REPEAT_CNT - 1);

    // Pin level that means "released"; the synchroniser resets to it so no
    // false press is seen after reset.
    localparam logic REL_LVL = (ACTIVE_LOW != 0);

    logic [N_CH-1:0] r_sync1;
    logic [N_CH-1:0] r_sync2;
    logic [N_CH-1:0] r_lo_key;
    logic [N_CH-1:0] r_press_p;
    logic [N_CH-1:0] r_release_p;
    logic [N_CH-1:0] r_long_p;
    logic [N_CH-1:0] r_rep_p;
    logic [DW-1:0]   r_deb_cnt  [N_CH];
    logic [HW-1:0]   r_hold_cnt [N_CH];
    logic [RW-1:0]   r_rep_cnt  [N_CH];

    logic [N_CH-1:0] w_lvl;
    logic [N_CH-1:0] w_acc;

    // Normalised level: 1 = pressed regardless of pin polarity
    assign w_lvl = r_sync2 ^ {N_CH{REL_LVL}};

    // Acceptance strobe: new level has persisted for the full debounce window
    always_comb begin
        w_acc = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_acc[i] = (w_lvl[i] != r_lo_key[i]) && (r_deb_cnt[i] == DEB_MAX);
        end
    end

    // Two-flop synchroniser for the asynchronous pins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= {N_CH{REL_LVL}};
            r_sync2 <= {N_CH{REL_LVL}};
        end else begin
            r_sync1 <= bus.key;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce counter, accepted level and press/release pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lo_key    <= '0;
            r_press_p   <= '0;
            r_release_p <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            r_press_p   <= w_acc & w_lvl;
            r_release_p <= w_acc & ~w_lvl;
            for (int i = 0; i < N_CH; i++) begin
                if (w_lvl[i] == r_lo_key[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (w_acc[i]) begin
                    r_lo_key[i]  <= w_lvl[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Saturating hold timer; long_p fires once on reaching LONG_CNT
    always_ff @(posedge clk) begin
        if (rst) begin
            r_long_p <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_hold_cnt[i] <= '0;
            end
        end else begin
            r_long_p <= '0;
            for (int i = 0; i < N_CH; i++) begin
                // w_acc covers both the press edge (restart) and the release
                // edge (abort any long_p that would land on it)
                if (!r_lo_key[i] || w_acc[i]) begin
                    r_hold_cnt[i] <= '0;
                end else if (r_hold_cnt[i] != HOLD_MAX) begin
                    r_hold_cnt[i] <= r_hold_cnt[i] + 1'b1;
                    if (r_hold_cnt[i] == HOLD_PRE) begin
                        r_long_p[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Auto-repeat timer, running only once the hold timer has saturated
    always_ff @(posedge clk) begin
        if (rst || (REPEAT_EN == 0)) begin
            r_rep_p <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_rep_cnt[i] <= '0;
            end
        end else begin
            r_rep_p <= '0;
            for (int i = 0; i < N_CH; i++) begin
                if (!r_lo_key[i] || w_acc[i]) begin
                    r_rep_cnt[i] <= '0;
                end else if (r_hold_cnt[i] == HOLD_PRE) begin
                    r_rep_cnt[i] <= '0;
                end else if (r_hold_cnt[i] == HOLD_MAX) begin
                    if (r_rep_cnt[i] == REP_MAX) begin
                        r_rep_cnt[i] <= '0;
                        r_rep_p[i]   <= 1'b1;
                    end else begin
                        r_rep_cnt[i] <= r_rep_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.lo_key    = r_lo_key;
    assign bus.press_p   = r_press_p;
    assign bus.release_p = r_release_p;
    assign bus.long_p    = r_long_p;
    assign bus.rep_p     = r_rep_p;

endmodule
